// File: rtl/buzzer_scheduler.sv
// buzzer_scheduler
//   Shares one buzzer square-wave generator between three requesters
//   (key beep, hourly chime, alarm). Arbitrates by fixed priority
//   alarm > chime > key, and sequences the winner's ON/OFF pattern from a
//   1 ms time base derived from clk.
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-low
//   key_req      one-cycle pulse, request a single key beep
//   chime_req    one-cycle pulse, request an hourly chime
//   chime_count  number of chime beeps, sampled with chime_req (0 ignored, >12 clamped)
//   alarm_on     level, alarm sounds while high
//   tone_en      generator gate, 1 = sound
//   tone_cycle   generator tone period (0 when idle)
//   busy         high while any source is active
//   active_src   00 none, 01 key, 10 chime, 11 alarm
module buzzer_scheduler #(
  parameter int unsigned CLK_PER_MS   = 50000,
  parameter int unsigned KEY_ON_MS    = 50,
  parameter int unsigned CHIME_ON_MS  = 200,
  parameter int unsigned CHIME_OFF_MS = 200,
  parameter int unsigned ALARM_ON_MS  = 100,
  parameter int unsigned ALARM_OFF_MS = 100,
  parameter logic [31:0] KEY_CYCLE    = 32'd25000,
  parameter logic [31:0] CHIME_CYCLE  = 32'd50000,
  parameter logic [31:0] ALARM_CYCLE  = 32'd20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_req,
  input  logic        chime_req,
  input  logic [3:0]  chime_count,
  input  logic        alarm_on,
  output logic        tone_en,
  output logic [31:0] tone_cycle,
  output logic        busy,
  output logic [1:0]  active_src
);

  localparam int unsigned    PW         = $clog2(CLK_PER_MS) + 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_PER_MS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;
  // Encoding doubles as priority: a larger value preempts a smaller one.
  typedef enum logic [1:0] {
    SRC_NONE  = 2'b00,
    SRC_KEY   = 2'b01,
    SRC_CHIME = 2'b10,
    SRC_ALARM = 2'b11
  } src_t;

  state_t        state_q, state_d;
  src_t          src_q, src_d;
  src_t          req_src;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   ms_q, ms_d;
  logic [3:0]    beeps_q, beeps_d;
  logic          tone_en_q, tone_en_d;
  logic [31:0]   tone_cycle_q, tone_cycle_d;
  logic          busy_q, busy_d;
  logic [1:0]    active_src_q, active_src_d;
  logic [15:0]   seg_len;
  logic          seg_done;
  logic          to_idle;
  logic [3:0]    chime_n;

  // Highest-priority request presented this cycle.
  always_comb begin
    req_src = SRC_NONE;
    if (alarm_on)                             req_src = SRC_ALARM;
    else if (chime_req && chime_count != '0)  req_src = SRC_CHIME;
    else if (key_req)                         req_src = SRC_KEY;
  end

  assign chime_n = (chime_count > 4'd12) ? 4'd12 : chime_count;

  // Length in ms of the segment currently running.
  always_comb begin
    seg_len = 16'd1;
    case (src_q)
      SRC_KEY:   seg_len = 16'(KEY_ON_MS);
      SRC_CHIME: seg_len = (state_q == S_ON) ? 16'(CHIME_ON_MS) : 16'(CHIME_OFF_MS);
      SRC_ALARM: seg_len = (state_q == S_ON) ? 16'(ALARM_ON_MS) : 16'(ALARM_OFF_MS);
      default:   seg_len = 16'd1;
    endcase
  end

  // Counters start at 0 on segment entry, so the last cycle of an X ms
  // segment is the one with ms_q == X-1 and the prescaler at its top.
  assign seg_done = (presc_q == PRESC_LAST) && (ms_q == seg_len - 16'd1);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    beeps_d = beeps_q;
    to_idle = 1'b0;
    presc_d = presc_q + 1'b1;
    ms_d    = ms_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      ms_d    = ms_q + 16'd1;
    end

    if (state_q != S_IDLE && src_q == SRC_ALARM && !alarm_on) begin
      to_idle = 1'b1;
    end else if (req_src > src_q) begin
      state_d = S_ON;
      src_d   = req_src;
      presc_d = '0;
      ms_d    = '0;
      beeps_d = (req_src == SRC_CHIME) ? chime_n : '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          presc_d = '0;
          ms_d    = '0;
        end
        S_ON: begin
          if (seg_done) begin
            presc_d = '0;
            ms_d    = '0;
            if (src_q == SRC_ALARM) begin
              state_d = S_OFF;
            end else if (src_q == SRC_CHIME && beeps_q > 4'd1) begin
              state_d = S_OFF;
              beeps_d = beeps_q - 4'd1;
            end else begin
              to_idle = 1'b1;
            end
          end
        end
        S_OFF: begin
          if (seg_done) begin
            state_d = S_ON;
            presc_d = '0;
            ms_d    = '0;
          end
        end
        default: to_idle = 1'b1;
      endcase
    end

    if (to_idle) begin
      state_d = S_IDLE;
      src_d   = SRC_NONE;
      presc_d = '0;
      ms_d    = '0;
      beeps_d = '0;
    end

    // Outputs are registered from the next-state values so they track state_q.
    tone_en_d    = (state_d == S_ON);
    busy_d       = (state_d != S_IDLE);
    active_src_d = src_d;
    case (src_d)
      SRC_KEY:   tone_cycle_d = KEY_CYCLE;
      SRC_CHIME: tone_cycle_d = CHIME_CYCLE;
      SRC_ALARM: tone_cycle_d = ALARM_CYCLE;
      default:   tone_cycle_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      src_q        <= SRC_NONE;
      presc_q      <= '0;
      ms_q         <= '0;
      beeps_q      <= '0;
      tone_en_q    <= 1'b0;
      tone_cycle_q <= '0;
      busy_q       <= 1'b0;
      active_src_q <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      presc_q      <= presc_d;
      ms_q         <= ms_d;
      beeps_q      <= beeps_d;
      tone_en_q    <= tone_en_d;
      tone_cycle_q <= tone_cycle_d;
      busy_q       <= busy_d;
      active_src_q <= active_src_d;
    end
  end

  assign tone_en    = tone_en_q;
  assign tone_cycle = tone_cycle_q;
  assign busy       = busy_q;
  assign active_src = active_src_q;

endmodule

// File: tb/tb_buzzer_scheduler.sv
// tb_buzzer_scheduler
//   Scoreboard bench: a pattern-list reference model runs at every rising
//   edge and queues the expected outputs; a monitor on the falling edge pops
//   and compares them against the DUT.
module tb_buzzer_scheduler;

  localparam int unsigned C     = 10;
  localparam int unsigned K_ON  = 5;
  localparam int unsigned CH_ON = 2;
  localparam int unsigned CH_OF = 3;
  localparam int unsigned A_ON  = 4;
  localparam int unsigned A_OF  = 1;

  logic        clk;
  logic        rst;
  logic        key_req;
  logic        chime_req;
  logic [3:0]  chime_count;
  logic        alarm_on;
  logic        tone_en;
  logic [31:0] tone_cycle;
  logic        busy;
  logic [1:0]  active_src;

  buzzer_scheduler #(
    .CLK_PER_MS   (C),
    .KEY_ON_MS    (K_ON),
    .CHIME_ON_MS  (CH_ON),
    .CHIME_OFF_MS (CH_OF),
    .ALARM_ON_MS  (A_ON),
    .ALARM_OFF_MS (A_OF),
    .KEY_CYCLE    (32'd100),
    .CHIME_CYCLE  (32'd200),
    .ALARM_CYCLE  (32'd300)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_req     (key_req),
    .chime_req   (chime_req),
    .chime_count (chime_count),
    .alarm_on    (alarm_on),
    .tone_en     (tone_en),
    .tone_cycle  (tone_cycle),
    .busy        (busy),
    .active_src  (active_src)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        en;
    logic [31:0] cyc;
    logic        bsy;
    logic [1:0]  src;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // Reference model: the active pattern is a list of segment lengths in
  // cycles (positive = sounding, negative = silent); rem counts down the head.
  int cur = 0;
  int pat[$];
  int rem = 0;

  function automatic int abs_i(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic start_src(input int s, input int cnt);
    int n;
    pat.delete();
    cur = s;
    if (s == 1) begin
      pat.push_back(K_ON * C);
    end else if (s == 2) begin
      n = (cnt > 12) ? 12 : cnt;
      for (int i = 0; i < n; i++) begin
        pat.push_back(CH_ON * C);
        if (i < n - 1) pat.push_back(-(CH_OF * C));
      end
    end else begin
      pat.push_back(A_ON * C);
      pat.push_back(-(A_OF * C));
    end
    rem = abs_i(pat[0]);
  endtask

  task automatic model_step();
    int   req;
    exp_t e;
    if (!rst) begin
      cur = 0;
      pat.delete();
    end else if (cur == 3 && !alarm_on) begin
      cur = 0;
      pat.delete();
    end else begin
      req = alarm_on ? 3 : ((chime_req && chime_count != 4'd0) ? 2 : (key_req ? 1 : 0));
      if (req > cur) begin
        start_src(req, int'(chime_count));
      end else if (cur != 0) begin
        rem--;
        if (rem == 0) begin
          void'(pat.pop_front());
          if (pat.size() == 0) begin
            if (cur == 3) begin
              pat.push_back(A_ON * C);
              pat.push_back(-(A_OF * C));
            end else begin
              cur = 0;
            end
          end
          if (cur != 0) rem = abs_i(pat[0]);
        end
      end
    end
    e.en  = (cur != 0) && (pat[0] > 0);
    e.cyc = (cur == 1) ? 32'd100 : (cur == 2) ? 32'd200 : (cur == 3) ? 32'd300 : 32'd0;
    e.bsy = (cur != 0);
    e.src = 2'(cur);
    exp_q.push_back(e);
  endtask

  always @(posedge clk) model_step();

  // Monitor: the DUT presents a registered output every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (tone_en !== e.en || tone_cycle !== e.cyc || busy !== e.bsy || active_src !== e.src) begin
          miscompares++;
          $display("FAIL outputs @%0t: got en=%b cyc=%0d busy=%b src=%b, expected en=%b cyc=%0d busy=%b src=%b",
                   $time, tone_en, tone_cycle, busy, active_src, e.en, e.cyc, e.bsy, e.src);
        end
      end
    end
  end

  // Drive inputs for one cycle, shortly after the rising edge.
  task automatic drive(input logic r, input logic k, input logic c, input logic [3:0] n, input logic a);
    rst = r; key_req = k; chime_req = c; chime_count = n; alarm_on = a;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles, input logic a);
    for (int i = 0; i < cycles; i++) drive(1'b1, 1'b0, 1'b0, 4'd0, a);
  endtask

  initial begin
    rst = 1'b0; key_req = 1'b0; chime_req = 1'b0; chime_count = 4'd0; alarm_on = 1'b0;
    // Reset with a request held: ignored.
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    idle(3, 1'b0);
    // Key beep.
    drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    idle(60, 1'b0);
    // Chimes: 3 beeps, 0 (ignored), 15 (clamped to 12).
    drive(1'b1, 1'b0, 1'b1, 4'd3, 1'b0);
    idle(130, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
    idle(5, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 4'd15, 1'b0);
    idle(580, 1'b0);
    // Key during chime, then chime+key together in idle.
    drive(1'b1, 1'b0, 1'b1, 4'd3, 1'b0);
    idle(10, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    idle(120, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 4'd2, 1'b0);
    idle(80, 1'b0);
    // Alarm preempts chime, then drops mid-ON; chime must not resume.
    drive(1'b1, 1'b0, 1'b1, 4'd3, 1'b0);
    idle(25, 1'b0);
    idle(70, 1'b1);
    idle(130, 1'b0);
    // Reset in alarm OFF segment, alarm restarts with a full beep.
    idle(44, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    idle(60, 1'b1);
    idle(5, 1'b0);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(499) != 0),
            ($urandom_range(19) == 0),
            ($urandom_range(59) == 0),
            4'($urandom_range(15)),
            ($urandom_range(149) == 0) ? ~alarm_on : alarm_on);
    end
    idle(3, 1'b0);
    @(negedge clk);
    #1;
    if (exp_q.size() > 1) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required at most 1", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
